// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access kinds, checker error record and the check-scheduler FSM states.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2,
    ACC_EXEC  = 2'd3
  } access_t;

  typedef struct packed {
    logic        error_detected;
    logic [3:0]  etype;
    logic [7:0]  sid;
    logic [15:0] eid;
    logic [63:0] addr;
  } error_capture_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } chk_state_e;

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Round-robin arbiter: search starts at the port after the last grant; pointer moves only on en_i.
module rv_iopmp_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] p;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    p     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // modulo without a divider so non-power-of-two port counts still wrap
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_PORTS)) sum = sum - (IDX_W+1)'(NUM_PORTS);
      p = sum[IDX_W-1:0];
      if (!found && req_i[p]) begin
        found    = 1'b1;
        gnt_o[p] = 1'b1;
        idx_o    = p;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (en_i && found) begin
      ptr_q <= (idx_o == IDX_W'(NUM_PORTS-1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/rv_iopmp_check_scheduler.sv
// Time-multiplexes one shared IOPMP checker across NUM_PORTS requesters:
// grant -> hold checker inputs CHECK_LATENCY cycles -> present verdict until consumed.
module rv_iopmp_check_scheduler
  import rv_iopmp_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int SID_WIDTH     = 8,
  parameter int NUM_PORTS     = 2,
  parameter int CHECK_LATENCY = 2,
  parameter int NB_W          = $clog2(DATA_WIDTH/8)+1,
  parameter int IDX_W         = $clog2(NUM_PORTS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_PORTS-1:0]                 req_valid_i,
  output logic [NUM_PORTS-1:0]                 req_ready_o,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS-1:0][NB_W-1:0]       req_num_bytes_i,
  input  logic [NUM_PORTS-1:0][SID_WIDTH-1:0]  req_sid_i,
  input  access_t [NUM_PORTS-1:0]              req_access_i,
  output logic [NUM_PORTS-1:0]                 rsp_valid_o,
  output logic                                 rsp_allow_o,
  input  logic [NUM_PORTS-1:0]                 rsp_ready_i,
  output logic                                 chk_en_o,
  output logic [ADDR_WIDTH-1:0]                chk_addr_o,
  output logic [NB_W-1:0]                      chk_num_bytes_o,
  output logic [SID_WIDTH-1:0]                 chk_sid_o,
  output access_t                              chk_access_o,
  input  logic                                 chk_allow_i,
  input  error_capture_t                       chk_err_i,
  output logic                                 err_valid_o,
  output error_capture_t                       err_o,
  output logic [IDX_W-1:0]                     err_port_o
);

  chk_state_e                 state_q;
  logic [2:0]                 cnt_q;
  logic [IDX_W-1:0]           gnt_idx_q;
  logic [NUM_PORTS-1:0]       rsp_valid_q;
  logic                       rsp_allow_q;
  logic                       chk_en_q;
  logic [ADDR_WIDTH-1:0]      chk_addr_q;
  logic [NB_W-1:0]            chk_nb_q;
  logic [SID_WIDTH-1:0]       chk_sid_q;
  access_t                    chk_access_q;
  logic                       err_valid_q;
  error_capture_t             err_q;
  logic [IDX_W-1:0]           err_port_q;

  logic                       arb_en;
  logic [NUM_PORTS-1:0]       arb_gnt;
  logic [IDX_W-1:0]           arb_idx;

  assign arb_en = (state_q == ST_IDLE) && !rst_i && (|req_valid_i);

  rv_iopmp_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (arb_en),
    .req_i (req_valid_i),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // ready must be combinational so the grant and the accept happen in the same cycle
  assign req_ready_o = arb_en ? arb_gnt : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gnt_idx_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_allow_q  <= 1'b0;
      chk_en_q     <= 1'b0;
      chk_addr_q   <= '0;
      chk_nb_q     <= '0;
      chk_sid_q    <= '0;
      chk_access_q <= ACC_NONE;
      err_valid_q  <= 1'b0;
      err_q        <= '0;
      err_port_q   <= '0;
    end else begin
      err_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_valid_i) begin
            state_q      <= ST_CHECK;
            gnt_idx_q    <= arb_idx;
            cnt_q        <= 3'(CHECK_LATENCY);
            chk_en_q     <= 1'b1;
            chk_addr_q   <= req_addr_i[arb_idx];
            chk_nb_q     <= req_num_bytes_i[arb_idx];
            chk_sid_q    <= req_sid_i[arb_idx];
            chk_access_q <= req_access_i[arb_idx];
          end
        end
        ST_CHECK: begin
          if (cnt_q == 3'd1) begin
            state_q                <= ST_RESP;
            cnt_q                  <= '0;
            chk_en_q               <= 1'b0;
            rsp_allow_q            <= chk_allow_i;
            rsp_valid_q[gnt_idx_q] <= 1'b1;
            if (chk_err_i.error_detected) begin
              err_valid_q <= 1'b1;
              err_q       <= chk_err_i;
              err_port_q  <= gnt_idx_q;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[gnt_idx_q]) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_allow_o     = rsp_allow_q;
  assign chk_en_o        = chk_en_q;
  assign chk_addr_o      = chk_addr_q;
  assign chk_num_bytes_o = chk_nb_q;
  assign chk_sid_o       = chk_sid_q;
  assign chk_access_o    = chk_access_q;
  assign err_valid_o     = err_valid_q;
  assign err_o           = err_q;
  assign err_port_o      = err_port_q;

endmodule

// File: tb/tb_rv_iopmp_check_scheduler.sv
// Directed bench for rv_iopmp_check_scheduler with default parameters (2 ports, latency 2).
module tb_rv_iopmp_check_scheduler;
  import rv_iopmp_pkg::*;

  localparam int AW = 64;
  localparam int SW = 8;
  localparam int NP = 2;
  localparam int NBW = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NP-1:0]         req_valid;
  logic [NP-1:0]         req_ready;
  logic [NP-1:0][AW-1:0] req_addr;
  logic [NP-1:0][NBW-1:0] req_nb;
  logic [NP-1:0][SW-1:0] req_sid;
  access_t [NP-1:0]      req_acc;
  logic [NP-1:0]         rsp_valid;
  logic                  rsp_allow;
  logic [NP-1:0]         rsp_ready;
  logic                  chk_en;
  logic [AW-1:0]         chk_addr;
  logic [NBW-1:0]        chk_nb;
  logic [SW-1:0]         chk_sid;
  access_t               chk_acc;
  logic                  chk_allow;
  error_capture_t        chk_err;
  logic                  err_valid;
  error_capture_t        err;
  logic                  err_port;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv_iopmp_check_scheduler dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_num_bytes_i(req_nb), .req_sid_i(req_sid), .req_access_i(req_acc),
    .rsp_valid_o(rsp_valid), .rsp_allow_o(rsp_allow), .rsp_ready_i(rsp_ready),
    .chk_en_o(chk_en), .chk_addr_o(chk_addr), .chk_num_bytes_o(chk_nb),
    .chk_sid_o(chk_sid), .chk_access_o(chk_acc),
    .chk_allow_i(chk_allow), .chk_err_i(chk_err),
    .err_valid_o(err_valid), .err_o(err), .err_port_o(err_port)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready != '0) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; req_addr = '0; req_nb = '0; req_sid = '0;
    req_acc = {ACC_NONE, ACC_NONE}; chk_allow = 1'b0; chk_err = '0;
    tick(); tick();
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 00", rsp_valid); end
    n_cmp++; if (rsp_allow !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_allow got %b want 0", rsp_allow); end
    n_cmp++; if (chk_en !== 1'b0) begin n_bad++; $display("FAIL rst_chk_en got %b want 0", chk_en); end
    n_cmp++; if (chk_addr !== '0) begin n_bad++; $display("FAIL rst_chk_addr got %h want 0", chk_addr); end
    n_cmp++; if (err_valid !== 1'b0 || err !== '0 || err_port !== 1'b0) begin
      n_bad++; $display("FAIL rst_err got v=%b e=%h p=%b want 0/0/0", err_valid, err, err_port); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    int c; bit ok;
    logic [NP-1:0] exp_g;
    logic [AW-1:0] exp_a;
    req_addr[0] = 64'h1000; req_addr[1] = 64'h2000;
    req_valid = 2'b11; rsp_ready = 2'b11; chk_allow = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 64'h1000 : 64'h2000;
      wait_grant(c, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL alt_grant_timeout k=%0d", k); end
      else if (req_ready !== exp_g) begin n_bad++; $display("FAIL alt_grant k=%0d got %b want %b", k, req_ready, exp_g); end
      if (k > 0) begin
        n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL alt_b2b_gap k=%0d got %0d want 3", k, c); end
      end
      tick();
      n_cmp++; if (chk_addr !== exp_a || chk_en !== 1'b1) begin
        n_bad++; $display("FAIL alt_chk k=%0d got en=%b a=%h want 1/%h", k, chk_en, chk_addr, exp_a); end
    end
    req_valid = '0;
    tick(); tick(); tick();
    rsp_ready = '0;
  endtask

  task automatic test_single_read();
    req_addr[0] = 64'h8000_0000; req_nb[0] = 4'd8; req_sid[0] = 8'd5; req_acc[0] = ACC_READ;
    chk_allow = 1'b1; chk_err = '0; req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rd_grant got %b want 01", req_ready); end
    tick(); req_valid = '0;
    n_cmp++; if (chk_en !== 1'b1 || chk_addr !== 64'h8000_0000 || chk_sid !== 8'd5 || chk_nb !== 4'd8 || chk_acc !== ACC_READ) begin
      n_bad++; $display("FAIL rd_chk got en=%b a=%h sid=%0d nb=%0d acc=%0d", chk_en, chk_addr, chk_sid, chk_nb, chk_acc); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rd_early_rsp1 got %b want 00", rsp_valid); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b00 || chk_en !== 1'b1) begin n_bad++; $display("FAIL rd_early_rsp2 got v=%b en=%b want 00/1", rsp_valid, chk_en); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1) begin n_bad++; $display("FAIL rd_rsp got v=%b a=%b want 01/1", rsp_valid, rsp_allow); end
    n_cmp++; if (chk_en !== 1'b0 || chk_addr !== 64'h8000_0000 || err_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_chk_hold got en=%b a=%h ev=%b want 0/80000000/0", chk_en, chk_addr, err_valid); end
    rsp_ready = 2'b01;
    tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rd_rsp_done got %b want 00", rsp_valid); end
    rsp_ready = '0;
  endtask

  task automatic test_error();
    req_addr[1] = 64'h4000; req_sid[1] = 8'd9; req_acc[1] = ACC_WRITE; req_nb[1] = 4'd4;
    chk_allow = 1'b0;
    chk_err = '{error_detected: 1'b1, etype: 4'd3, sid: 8'd9, eid: 16'd7, addr: 64'h4000};
    req_valid = 2'b10;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL err_grant got %b want 10", req_ready); end
    tick(); req_valid = '0;
    tick();
    n_cmp++; if (err_valid !== 1'b0) begin n_bad++; $display("FAIL err_early got %b want 0", err_valid); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_allow !== 1'b0) begin n_bad++; $display("FAIL err_rsp got v=%b a=%b want 10/0", rsp_valid, rsp_allow); end
    n_cmp++; if (err_valid !== 1'b1 || err_port !== 1'b1 || err.etype !== 4'd3 || err.eid !== 16'd7) begin
      n_bad++; $display("FAIL err_rec got v=%b p=%b et=%0d eid=%0d want 1/1/3/7", err_valid, err_port, err.etype, err.eid); end
    rsp_ready = 2'b01;
    tick();
    n_cmp++; if (err_valid !== 1'b0 || rsp_valid !== 2'b10) begin
      n_bad++; $display("FAIL err_pulse_or_wrong_port_ready got ev=%b v=%b want 0/10", err_valid, rsp_valid); end
    rsp_ready = 2'b10;
    tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL err_rsp_done got %b want 00", rsp_valid); end
    rsp_ready = '0; chk_err = '0; chk_allow = 1'b1;
  endtask

  task automatic test_stall();
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL stall_grant got %b want 01", req_ready); end
    tick(); req_valid = 2'b10;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1 || req_ready !== 2'b00) begin
        n_bad++; $display("FAIL stall_hold i=%0d got v=%b a=%b rdy=%b want 01/1/00", i, rsp_valid, rsp_allow, req_ready); end
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    n_cmp++; if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      n_bad++; $display("FAIL stall_next_grant got rdy=%b v=%b want 10/00", req_ready, rsp_valid); end
    req_valid = '0; rsp_ready = 2'b11;
    tick(); tick(); tick(); tick();
    n_cmp++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      n_bad++; $display("FAIL stall_drain got v=%b rdy=%b want 00/00", rsp_valid, req_ready); end
    rsp_ready = '0;
  endtask

  task automatic test_reset_mid_check();
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmc_grant got %b want 01", req_ready); end
    tick(); req_valid = '0; rst = 1'b1;
    tick();
    n_cmp++; if (chk_en !== 1'b0 || chk_addr !== '0 || chk_sid !== '0 || req_ready !== 2'b00) begin
      n_bad++; $display("FAIL rmc_chk got en=%b a=%h sid=%0d rdy=%b want all 0", chk_en, chk_addr, chk_sid, req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00 || rsp_allow !== 1'b0 || err_valid !== 1'b0 || err !== '0 || err_port !== 1'b0) begin
      n_bad++; $display("FAIL rmc_out got v=%b a=%b ev=%b e=%h p=%b want all 0", rsp_valid, rsp_allow, err_valid, err, err_port); end
    rst = 1'b0; req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmc_ptr got %b want 01", req_ready); end
    tick(); req_valid = '0;
    tick(); tick();
    n_cmp++; if (rsp_valid !== 2'b01 || err_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmc_rsp got v=%b ev=%b want 01/0", rsp_valid, err_valid); end
    rsp_ready = 2'b01;
    tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rmc_done got %b want 00", rsp_valid); end
    rsp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single_read();
    test_error();
    test_stall();
    test_reset_mid_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_iopmp_check_scheduler.md
RV_IOPMP_CHECK_SCHEDULER -- requirements
Module: rv_iopmp_check_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data bus width; NB_W = $clog2(DATA_WIDTH/8)+1.
REQ-003 SHALL have parameter SID_WIDTH, default 8, source-ID width.
REQ-004 SHALL have parameter NUM_PORTS, default 2, number of requesters (port 0 = read, port 1 = write); legal range 2..8.
REQ-005 SHALL have parameter CHECK_LATENCY, default 2, cycles from checker inputs stable to checker result valid; legal range 1..7.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk_i  input  1  rising-edge clock; rst_i  input  1  synchronous active-high reset.
REQ-007 req_valid_i  input  NUM_PORTS  per-port check request valid.
REQ-008 req_ready_o  output  NUM_PORTS  per-port request accepted this cycle.
REQ-009 req_addr_i  input  NUM_PORTS x ADDR_WIDTH  per-port address.
REQ-010 req_num_bytes_i  input  NUM_PORTS x NB_W  per-port access size in bytes.
REQ-011 req_sid_i  input  NUM_PORTS x SID_WIDTH  per-port source ID.
REQ-012 req_access_i  input  NUM_PORTS x rv_iopmp_pkg::access_t  per-port access type.
REQ-013 rsp_valid_o  output  NUM_PORTS  per-port verdict valid.
REQ-014 rsp_allow_o  output  1  verdict (1 = allow), qualified by rsp_valid_o.
REQ-015 rsp_ready_i  input  NUM_PORTS  per-port verdict consumed.
REQ-016 chk_en_o / chk_addr_o / chk_num_bytes_o / chk_sid_o / chk_access_o  output  1 / ADDR_WIDTH / NB_W / SID_WIDTH / access_t  drive to the shared transaction checker.
REQ-017 chk_allow_i  input  1  checker verdict; chk_err_i  input  rv_iopmp_pkg::error_capture_t  checker error record.
REQ-018 err_valid_o  output  1  one-cycle pulse: captured error record valid; err_o  output  error_capture_t  registered error record; err_port_o  output  $clog2(NUM_PORTS)  port that caused it.

Function
REQ-019 SHALL implement FSM states IDLE, CHECK, RESP.
REQ-020 IDLE: when any req_valid_i set, SHALL grant one port by round-robin (priority starts at port after last grant; after reset, port 0 first), assert req_ready_o for that port only in that cycle, latch its request, go to CHECK.
REQ-021 req_ready_o SHALL be 0 for all ports outside the IDLE grant cycle; at most one bit set per cycle.
REQ-022 CHECK: chk_en_o = 1 and chk_* SHALL hold latched request stable; a down-counter loaded with CHECK_LATENCY SHALL decrement each cycle; at count 1, sample chk_allow_i and chk_err_i, go to RESP.
REQ-023 Outside CHECK, chk_en_o SHALL be 0 and chk_* data SHALL hold last values.
REQ-024 RESP: rsp_valid_o bit of granted port SHALL be 1, rsp_allow_o = sampled verdict, held stable until rsp_ready_i of that port; on handshake go to IDLE.
REQ-025 Grant-to-response latency SHALL be exactly CHECK_LATENCY+1 cycles (grant cycle, CHECK_LATENCY checker cycles, then rsp_valid_o).
REQ-026 If sampled chk_err_i.error_detected = 1, SHALL pulse err_valid_o for one cycle on RESP entry with err_o and err_port_o registered; else err_valid_o = 0.
REQ-027 A port deasserting req_valid_i without grant SHALL be legal; no request SHALL be lost or duplicated once granted.
REQ-028 rsp_ready_i on non-granted ports SHALL be ignored; rsp_ready_i held high on entering RESP SHALL complete handshake in the first RESP cycle.
REQ-029 Back-to-back: after RESP handshake, next grant SHALL occur no earlier than following IDLE cycle (one idle bubble).

Reset
REQ-030 On rst_i = 1 at clock edge: state = IDLE, round-robin pointer = port 0, counter = 0, req_ready_o = 0, rsp_valid_o = 0, rsp_allow_o = 0, chk_en_o = 0, chk_* data = 0, err_valid_o = 0, err_o = 0, err_port_o = 0.
REQ-031 Reset asserted mid-CHECK or mid-RESP SHALL abandon the transaction without response or error pulse.

Structure
REQ-032 access_t and error_capture_t SHALL be taken from rv_iopmp_pkg; FSM state enum SHALL be added to rv_iopmp_pkg.
REQ-033 Round-robin arbiter SHALL be a sub-module rv_iopmp_rr_arbiter (request vector in, one-hot grant and index out, pointer update on enable).

Verification
REQ-034 Single read request addr 0x8000_0000, chk_allow_i = 1, CHECK_LATENCY = 2 -> rsp_valid_o[0] 3 cycles after grant, rsp_allow_o = 1.
REQ-035 Ports 0 and 1 valid continuously -> grants alternate 0,1,0,1; no port granted twice in a row.
REQ-036 chk_allow_i = 0 with error_detected = 1, etype = 3 on port 1 -> rsp_allow_o = 0, err_valid_o single pulse, err_port_o = 1, err_o.etype = 3.
REQ-037 rsp_ready_i[0] held low 5 cycles in RESP -> rsp_valid_o/rsp_allow_o stable, no new grant, req_ready_o = 0 throughout.
REQ-038 rst_i asserted during CHECK -> next cycle all outputs at reset values; subsequent request on port 1 granted after port 0 request only if port 0 valid (pointer reset to 0).
